prog_mem: RTL and testbench

- Parametrised, boot-loadable instruction memory for the MCU core; next generation of the fixed combinational program ROM.
- The program is streamed in over a valid/ready load port after reset.
- The fetch side is a synchronous read with 1-cycle latency, stall support and out-of-range detection.
- Sits between the boot loader (or testbench) and the core's fetch stage.

---
 rtl/prog_mem_pkg.sv | 20 ++
 rtl/prog_mem_array.sv | 31 +++
 rtl/prog_mem.sv | 190 +++++++++++++++++++
 tb/tb_prog_mem.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_mem_pkg.sv
// Shared types, constants and helpers for the boot-loadable program memory.
package prog_mem_pkg;

    localparam int unsigned NOP_W     = 14;
    localparam int unsigned PAR_MAX_W = 64;

    localparam logic [NOP_W-1:0] NOP_WORD = 14'h0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // Even parity bit: makes the total count of ones (data + bit) even.
    function automatic logic calc_parity(input logic [PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/prog_mem_array.sv
// Single-write, single-read synchronous RAM with a registered read port and no reset.
module prog_mem_array #(
    parameter int unsigned WIDTH = 14,
    parameter int unsigned DEPTH = 2048,
    parameter int unsigned IDX_W = 11
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Write port and registered read port; read data holds while rd_en is low.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/prog_mem.sv
// Boot-loadable instruction memory: IDLE -> LOAD (valid/ready stream) -> RUN (1-cycle fetch).
// Optional macro PROG_MEM_PARITY_EN adds a stored parity bit per word and a sticky par_err output.
module prog_mem
    import prog_mem_pkg::*;
#(
    parameter int unsigned        DATA_W   = 14,
    parameter int unsigned        ADDR_W   = 11,
    parameter int unsigned        DEPTH    = 2048,
    parameter logic [DATA_W-1:0]  OOR_WORD = DATA_W'(NOP_WORD)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boot_start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid,
    output logic              oor_flag,
    output logic [ADDR_W:0]   prog_len,
`ifdef PROG_MEM_PARITY_EN
    output logic              par_err,
`endif
    output logic [1:0]        state_o
);

    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef PROG_MEM_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [LEN_W-1:0]  prog_len_q, prog_len_d;
    logic              instr_valid_q, instr_valid_d;
    logic              oor_flag_q, oor_flag_d;
    logic              use_mem_q, use_mem_d;
    logic              ld_ready_q, ld_ready_d;
    logic              wr_en_c;
    logic              rd_en_c;
    logic              in_range_c;
    logic [MEM_W-1:0]  wr_word_c;
    logic [MEM_W-1:0]  rd_word;
    logic              par_bad_c;

    assign in_range_c = {1'b0, fetch_addr} < prog_len_q;

`ifdef PROG_MEM_PARITY_EN
    logic par_err_q, par_err_d;

    assign wr_word_c = {calc_parity(PAR_MAX_W'(ld_data)), ld_data};
    assign par_bad_c = use_mem_q &&
                       (rd_word[DATA_W] != calc_parity(PAR_MAX_W'(rd_word[DATA_W-1:0])));

    // Sticky parity error; a new boot clears it.
    always_comb begin
        par_err_d = par_err_q;
        if (par_bad_c) begin
            par_err_d = 1'b1;
        end
        if (boot_start) begin
            par_err_d = 1'b0;
        end
    end

    // Parity error register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign par_err = par_err_q | par_bad_c;
`else
    assign wr_word_c = ld_data;
    assign par_bad_c = 1'b0;
`endif

    // Next-state, pointer and fetch-result logic.
    always_comb begin
        state_d       = state_q;
        wptr_d        = wptr_q;
        prog_len_d    = prog_len_q;
        instr_valid_d = instr_valid_q;
        oor_flag_d    = oor_flag_q;
        use_mem_d     = use_mem_q;
        wr_en_c       = 1'b0;
        rd_en_c       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (boot_start) begin
                    state_d       = ST_LOAD;
                    wptr_d        = '0;
                    prog_len_d    = '0;
                    instr_valid_d = 1'b0;
                    use_mem_d     = 1'b0;
                end
            end
            ST_LOAD: begin
                if (ld_valid && ld_ready_q) begin
                    wr_en_c    = 1'b1;
                    wptr_d     = wptr_q + ADDR_W'(1);
                    prog_len_d = prog_len_q + LEN_W'(1);
                    if (ld_last || (wptr_q == LAST_IDX)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (boot_start) begin
                    // A fetch in the same cycle as a reboot is dropped.
                    state_d       = ST_LOAD;
                    wptr_d        = '0;
                    prog_len_d    = '0;
                    instr_valid_d = 1'b0;
                    use_mem_d     = 1'b0;
                end else if (fetch_en) begin
                    instr_valid_d = 1'b1;
                    if (in_range_c) begin
                        rd_en_c    = 1'b1;
                        oor_flag_d = 1'b0;
                        use_mem_d  = 1'b1;
                    end else begin
                        oor_flag_d = 1'b1;
                        use_mem_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ld_ready_d = (state_d == ST_LOAD);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            wptr_q        <= '0;
            prog_len_q    <= '0;
            instr_valid_q <= 1'b0;
            oor_flag_q    <= 1'b0;
            use_mem_q     <= 1'b0;
            ld_ready_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wptr_q        <= wptr_d;
            prog_len_q    <= prog_len_d;
            instr_valid_q <= instr_valid_d;
            oor_flag_q    <= oor_flag_d;
            use_mem_q     <= use_mem_d;
            ld_ready_q    <= ld_ready_d;
        end
    end

    prog_mem_array #(
        .WIDTH (MEM_W),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en_c),
        .wr_addr (IDX_W'(wptr_q)),
        .wr_data (wr_word_c),
        .rd_en   (rd_en_c),
        .rd_addr (IDX_W'(fetch_addr)),
        .rd_data (rd_word)
    );

    // The array is the output register; use_mem_q selects it over the NOP word.
    assign instr_out   = (use_mem_q && !par_bad_c) ? rd_word[DATA_W-1:0] : OOR_WORD;
    assign instr_valid = instr_valid_q;
    assign oor_flag    = oor_flag_q;
    assign prog_len    = prog_len_q;
    assign ld_ready    = ld_ready_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem: default build plus a DEPTH=4 instance.
module tb_prog_mem;

    localparam int unsigned DATA_W = 14;
    localparam int unsigned ADDR_W = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic              boot_start = 1'b0;
    logic              ld_valid   = 1'b0;
    logic              ld_ready;
    logic [DATA_W-1:0] ld_data    = '0;
    logic              ld_last    = 1'b0;
    logic              fetch_en   = 1'b0;
    logic [ADDR_W-1:0] fetch_addr = '0;
    logic [DATA_W-1:0] instr_out;
    logic              instr_valid;
    logic              oor_flag;
    logic [ADDR_W:0]   prog_len;
    logic [1:0]        state_o;
`ifdef PROG_MEM_PARITY_EN
    logic              par_err;
    logic              par_err4;
`endif

    // DEPTH=4 instance
    logic              boot_start4 = 1'b0;
    logic              ld_valid4   = 1'b0;
    logic              ld_ready4;
    logic [DATA_W-1:0] ld_data4    = '0;
    logic              ld_last4    = 1'b0;
    logic              fetch_en4   = 1'b0;
    logic [ADDR_W-1:0] fetch_addr4 = '0;
    logic [DATA_W-1:0] instr_out4;
    logic              instr_valid4;
    logic              oor_flag4;
    logic [ADDR_W:0]   prog_len4;
    logic [1:0]        state_o4;

    int n_vec = 0;
    int n_err = 0;

    prog_mem u_dut (
        .clk         (clk),
        .rst         (rst),
        .boot_start  (boot_start),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .fetch_en    (fetch_en),
        .fetch_addr  (fetch_addr),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .oor_flag    (oor_flag),
        .prog_len    (prog_len),
`ifdef PROG_MEM_PARITY_EN
        .par_err     (par_err),
`endif
        .state_o     (state_o)
    );

    prog_mem #(.DEPTH(4)) u_dut4 (
        .clk         (clk),
        .rst         (rst),
        .boot_start  (boot_start4),
        .ld_valid    (ld_valid4),
        .ld_ready    (ld_ready4),
        .ld_data     (ld_data4),
        .ld_last     (ld_last4),
        .fetch_en    (fetch_en4),
        .fetch_addr  (fetch_addr4),
        .instr_out   (instr_out4),
        .instr_valid (instr_valid4),
        .oor_flag    (oor_flag4),
        .prog_len    (prog_len4),
`ifdef PROG_MEM_PARITY_EN
        .par_err     (par_err4),
`endif
        .state_o     (state_o4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fetch(input string tag, input logic [13:0] exp_instr, input logic exp_oor);
        check({tag, ".instr"}, 32'(instr_out),   32'(exp_instr));
        check({tag, ".valid"}, 32'(instr_valid), 32'd1);
        check({tag, ".oor"},   32'(oor_flag),    32'(exp_oor));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] words [3];
        logic [13:0] words4 [6];
        int          acc4;

        words[0] = 14'h01A5; words[1] = 14'h0103; words[2] = 14'h3006;
        words4[0] = 14'h0011; words4[1] = 14'h0022; words4[2] = 14'h0033;
        words4[3] = 14'h0044; words4[4] = 14'h0055; words4[5] = 14'h0066;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst.state",    32'(state_o),     32'd0);
        check("rst.prog_len", 32'(prog_len),    32'd0);
        check("rst.instr",    32'(instr_out),   32'h0000);
        check("rst.valid",    32'(instr_valid), 32'd0);
        check("rst.oor",      32'(oor_flag),    32'd0);
        check("rst.ld_ready", 32'(ld_ready),    32'd0);
        rst = 1'b0;
        tick();

        // Fetch in IDLE is ignored
        fetch_en = 1'b1; fetch_addr = '0;
        tick();
        fetch_en = 1'b0;
        check("idle.fetch_valid", 32'(instr_valid), 32'd0);
        check("idle.state",       32'(state_o),     32'd0);

        // Boot and load three words
        boot_start = 1'b1;
        tick();
        boot_start = 1'b0;
        check("boot.state",    32'(state_o),  32'd1);
        check("boot.ld_ready", 32'(ld_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_data = words[i]; ld_last = (i == 2);
            check($sformatf("load.ready%0d", i), 32'(ld_ready), 32'd1);
            tick();
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        check("load.prog_len", 32'(prog_len), 32'd3);
        check("load.state",    32'(state_o),  32'd2);
        check("load.ld_ready", 32'(ld_ready), 32'd0);

        // Back-to-back fetches
        for (int i = 0; i < 3; i++) begin
            fetch_en = 1'b1; fetch_addr = ADDR_W'(i);
            tick();
            check_fetch($sformatf("fetch%0d", i), words[i], 1'b0);
        end

        // Out-of-range fetch then stall
        fetch_addr = 11'd5;
        tick();
        check_fetch("fetch_oor", 14'h0000, 1'b1);
        fetch_en = 1'b0; fetch_addr = 11'd1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_fetch($sformatf("stall%0d", i), 14'h0000, 1'b1);
        end

        // Boundary fetch at prog_len exactly
        fetch_en = 1'b1; fetch_addr = 11'd3;
        tick();
        check_fetch("fetch_at_len", 14'h0000, 1'b1);
        fetch_addr = 11'd2;
        tick();
        check_fetch("fetch_last", 14'h3006, 1'b0);

        // Reboot from RUN with a simultaneous fetch (dropped)
        fetch_addr = 11'd0; boot_start = 1'b1;
        tick();
        boot_start = 1'b0; fetch_en = 1'b0;
        check("reboot.state",    32'(state_o),     32'd1);
        check("reboot.valid",    32'(instr_valid), 32'd0);
        check("reboot.prog_len", 32'(prog_len),    32'd0);

        // Load with gaps; boot_start in LOAD is ignored
        ld_valid = 1'b1; ld_data = 14'h1111;
        tick();
        ld_valid = 1'b0; boot_start = 1'b1;
        tick();
        boot_start = 1'b0;
        check("gap.prog_len1", 32'(prog_len), 32'd1);
        check("gap.state",     32'(state_o),  32'd1);
        tick();
        ld_valid = 1'b1; ld_data = 14'h2222;
        tick();
        ld_valid = 1'b0;
        check("gap.prog_len2", 32'(prog_len), 32'd2);

        // Asynchronous reset mid-load, sampled before any clock edge
        rst = 1'b1;
        #1;
        check("arst.state",    32'(state_o),     32'd0);
        check("arst.prog_len", 32'(prog_len),    32'd0);
        check("arst.valid",    32'(instr_valid), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Reload one word; stale words beyond it read as OOR
        boot_start = 1'b1;
        tick();
        boot_start = 1'b0;
        ld_valid = 1'b1; ld_data = 14'h3400; ld_last = 1'b1;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        check("reload.prog_len", 32'(prog_len), 32'd1);
        fetch_en = 1'b1; fetch_addr = 11'd0;
        tick();
        check_fetch("reload.f0", 14'h3400, 1'b0);
        fetch_addr = 11'd1;
        tick();
        check_fetch("reload.f1", 14'h0000, 1'b1);
        fetch_en = 1'b0;

`ifdef PROG_MEM_PARITY_EN
        // Corrupt stored parity; the fetch returns OOR_WORD and par_err sticks
        boot_start = 1'b1;
        tick();
        boot_start = 1'b0;
        ld_valid = 1'b1; ld_data = 14'h0725; ld_last = 1'b1;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        check("par.clean", 32'(par_err), 32'd0);
        u_dut.u_array.mem[0][DATA_W] = ~u_dut.u_array.mem[0][DATA_W];
        fetch_en = 1'b1; fetch_addr = 11'd0;
        tick();
        check("par.instr", 32'(instr_out), 32'h0000);
        check("par.err",   32'(par_err),   32'd1);
        fetch_addr = 11'd4;
        tick();
        fetch_en = 1'b0;
        repeat (2) tick();
        check("par.sticky", 32'(par_err), 32'd1);
        boot_start = 1'b1;
        tick();
        boot_start = 1'b0;
        check("par.cleared", 32'(par_err), 32'd0);
`endif

        // DEPTH=4: six words without ld_last, only four accepted
        boot_start4 = 1'b1;
        tick();
        boot_start4 = 1'b0;
        acc4 = 0;
        for (int i = 0; i < 6; i++) begin
            ld_valid4 = 1'b1; ld_data4 = words4[i];
            if (ld_ready4) acc4++;
            tick();
        end
        ld_valid4 = 1'b0;
        check("d4.accepted", 32'(acc4),      32'd4);
        check("d4.prog_len", 32'(prog_len4), 32'd4);
        check("d4.state",    32'(state_o4),  32'd2);
        check("d4.ld_ready", 32'(ld_ready4), 32'd0);
        fetch_en4 = 1'b1; fetch_addr4 = 11'd3;
        tick();
        check("d4.f3.instr", 32'(instr_out4), 32'h0044);
        check("d4.f3.oor",   32'(oor_flag4),  32'd0);
        fetch_addr4 = 11'd4;
        tick();
        check("d4.f4.instr", 32'(instr_out4), 32'h0000);
        check("d4.f4.oor",   32'(oor_flag4),  32'd1);
        fetch_en4 = 1'b0; boot_start4 = 1'b1;
        tick();
        boot_start4 = 1'b0;
        check("d4.reboot.state", 32'(state_o4),     32'd1);
        check("d4.reboot.valid", 32'(instr_valid4), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
